player_motion: RTL and testbench
================================

// Module: player_motion
// PURPOSE
//  Jetpack player physics stage. Once per video frame it integrates thrust and gravity
//  into a vertical velocity, then into a position. It drives the player bounding box
//  (x0,x1,y0,y1) consumed by the pixel animator.
//  Updates occur only on frame_tick (start of vblank), so the box is stable during active video.
// PARAMETERS
//  SCREEN_H    480  visible lines; y1 never exceeds SCREEN_H-1
//  PLAYER_X    100  fixed left edge of player box (pixels)
//  PLAYER_W    16   box width; x1 = PLAYER_X+PLAYER_W-1
//  PLAYER_H    24   box height; GROUND_Y0 = SCREEN_H-PLAYER_H (456)
//  THRUST_ACC  2    upward velocity change per update while thrust held
//  GRAVITY     1    downward velocity change per gravity step
//  GRAV_DIV    2    gravity applied on every GRAV_DIV-th non-thrust update
//  VMAX        6    |velocity| saturation, pixels/frame
// PORTS
//  clk         in   1   system/pixel clock
//  reset       in   1   synchronous, active-high
//  frame_tick  in   1   1-cycle pulse, once per frame
//  thrust      in   1   jetpack button, level; already synchronised and debounced upstream
//  game_over   in   1   level; freezes motion until reset
//  x0, x1      out  10  box left/right (constant from params)
//  y0, y1      out  9   box top/bottom, registered
//  on_ground   out  1   registered; y0 == GROUND_Y0
//  on_ceiling  out  1   registered; y0 == 0
//  flying      out  1   registered; high in any state except IDLE/FROZEN
// BEHAVIOUR
//  Reset (sync): state=IDLE, y0=GROUND_Y0, y1=SCREEN_H-1, vel=0, grav_cnt=0,
//   on_ground=1, on_ceiling=0, flying=0. reset overrides every other input,
//   including mid-update (VEL/POS) and FROZEN.
//  Internal: vel signed 5b; y math in signed 11b, then clamped to [0,GROUND_Y0]; thr_q = thrust at tick.
//  FSM (one-hot or enum, jetpack_pkg::pm_state_t):
//   IDLE:   frame_tick & thrust -> VEL (thr_q=1); frame_tick & !thrust -> stay, no change.
//   WAIT:   frame_tick -> VEL, thr_q<=thrust.
//   VEL:    thr_q: vel <= max(vel-THRUST_ACC, -VMAX), grav_cnt<=0.
//           else: grav_cnt<=(grav_cnt==GRAV_DIV-1)?0:grav_cnt+1; on wrap vel<=min(vel+GRAVITY,VMAX).
//           -> POS.
//   POS:    ny = y0+vel; ny<=0: y0<=0, vel<=0; ny>=GROUND_Y0: y0<=GROUND_Y0, vel<=0;
//           else y0<=ny. y1<=new y0+PLAYER_H-1; flags updated same edge. -> WAIT.
//   FROZEN: outputs and vel held; leaves only on reset.
//  game_over=1 in any state -> FROZEN next edge (abandons VEL/POS; y0 keeps last committed value).
//  Latency: y0/y1/flags change on the 3rd rising edge after the frame_tick edge (tick->VEL->POS->commit).
//  frame_tick during VEL/POS is ignored (no queuing). Landing keeps state WAIT (no return to IDLE).
//  Ceiling with thrust held: vel clamps to 0 each POS, y0 stays 0.
//  y1 always equals y0+PLAYER_H-1; y1<=SCREEN_H-1 at all times.
// STRUCTURE
//  jetpack_pkg: SCREEN_W/SCREEN_H constants, xcoord_t (logic[9:0]), ycoord_t (logic[8:0]),
//   pm_state_t enum {IDLE,WAIT,VEL,POS,FROZEN}, shared with animator and obstacle blocks.
//  Single module, no sub-module; saturating add/clamp as local functions.
// TESTING (defaults)
//  reset, 10 ticks thrust=0 -> y0=456,y1=479,x0=100,x1=115,on_ground=1,flying=0 throughout.
//  thrust=1 ticks 1..4 -> vel -2,-4,-6,-6; y0 454,450,444,438; flying=1; each change 3 edges after tick.
//  after that release thrust, ticks=0 -> vel +1 every 2nd tick, saturates at +6; never >+6.
//  hold thrust from ground -> y0 reaches 0, on_ceiling=1, vel=0, y0 stays 0 for further ticks.
//  from y0=452 falling vel=+6 -> y0=456, y1=479, on_ground=1, vel=0, next tick no motion w/o thrust.
//  game_over mid-flight (also asserted in VEL cycle) -> y0 frozen across 20 ticks+thrust;
//   reset -> y0=456, flying=0 one edge later; frame_tick on 2 consecutive cycles -> single update.

Source files
------------

// File: rtl/jetpack_pkg.sv
// Shared jetpack game types: screen geometry, coordinate types and the
// player-motion state encoding used by the animator and obstacle blocks.
package jetpack_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef logic [9:0] xcoord_t;
  typedef logic [8:0] ycoord_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    VEL,
    POS,
    FROZEN
  } pm_state_t;

endpackage

// File: rtl/player_motion.sv
// Jetpack player physics. Once per frame (on frame_tick) thrust/gravity are
// integrated into a signed velocity, then the velocity into a clamped
// vertical position. The bounding box only moves three edges after the tick,
// inside vblank, so the animator sees a stable box during active video.
module player_motion
  import jetpack_pkg::*;
#(
  parameter int SCREEN_H   = 480,
  parameter int PLAYER_X   = 100,
  parameter int PLAYER_W   = 16,
  parameter int PLAYER_H   = 24,
  parameter int THRUST_ACC = 2,
  parameter int GRAVITY    = 1,
  parameter int GRAV_DIV   = 2,
  parameter int VMAX       = 6
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    frame_tick,
  input  logic    thrust,
  input  logic    game_over,
  output xcoord_t x0,
  output xcoord_t x1,
  output ycoord_t y0,
  output ycoord_t y1,
  output logic    on_ground,
  output logic    on_ceiling,
  output logic    flying
);

  localparam int GC_W = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
  localparam logic signed [10:0] GROUND_S = 11'(SCREEN_H - PLAYER_H);
  localparam ycoord_t GROUND_Y0 = ycoord_t'(SCREEN_H - PLAYER_H);
  localparam ycoord_t BOX_H_M1  = ycoord_t'(PLAYER_H - 1);

  pm_state_t          state, next_state;
  logic signed [4:0]  vel;
  logic [GC_W-1:0]    grav_cnt;
  logic               thr_q;

  logic signed [4:0]  vel_thr, vel_grav;
  logic               grav_wrap;
  logic signed [10:0] ny;
  ycoord_t            y_new;
  logic               hit;

  // Velocity saturation to [-VMAX, VMAX]; operand is one bit wider than vel.
  function automatic logic signed [4:0] sat_vel(input logic signed [5:0] v);
    if (v > 6'(VMAX))       return 5'(VMAX);
    else if (v < -6'(VMAX)) return 5'(-VMAX);
    else                    return v[4:0];
  endfunction

  // Clamp a candidate position to the playfield [0, GROUND_Y0].
  function automatic ycoord_t clamp_y(input logic signed [10:0] v);
    if (v <= 11'sd0)         return '0;
    else if (v >= GROUND_S)  return GROUND_Y0;
    else                     return v[8:0];
  endfunction

  assign x0 = xcoord_t'(PLAYER_X);
  assign x1 = xcoord_t'(PLAYER_X + PLAYER_W - 1);

  // Candidate velocities/positions for the VEL and POS steps.
  always_comb begin
    vel_thr   = sat_vel({vel[4], vel} - 6'(THRUST_ACC));
    vel_grav  = sat_vel({vel[4], vel} + 6'(GRAVITY));
    grav_wrap = (grav_cnt == GC_W'(GRAV_DIV - 1));
    ny        = $signed({2'b00, y0}) + $signed({{6{vel[4]}}, vel});
    y_new     = clamp_y(ny);
    hit       = (ny <= 11'sd0) || (ny >= GROUND_S);
  end

  // Next-state: game_over wins from any state; FROZEN is only left via reset.
  always_comb begin
    next_state = state;
    if (game_over) next_state = FROZEN;
    else begin
      case (state)
        IDLE:    if (frame_tick && thrust) next_state = VEL;
        WAIT:    if (frame_tick) next_state = VEL;
        VEL:     next_state = POS;
        POS:     next_state = WAIT;
        FROZEN:  next_state = FROZEN;
        default: next_state = IDLE;
      endcase
    end
  end

  // State, physics registers and registered box/flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      vel        <= '0;
      grav_cnt   <= '0;
      thr_q      <= 1'b0;
      y0         <= GROUND_Y0;
      y1         <= ycoord_t'(SCREEN_H - 1);
      on_ground  <= 1'b1;
      on_ceiling <= 1'b0;
      flying     <= 1'b0;
    end else begin
      state  <= next_state;
      flying <= (next_state == WAIT) || (next_state == VEL) || (next_state == POS);
      if (!game_over) begin
        case (state)
          IDLE: if (frame_tick && thrust) thr_q <= 1'b1;
          WAIT: if (frame_tick) thr_q <= thrust;
          VEL: begin
            if (thr_q) begin
              vel      <= vel_thr;
              grav_cnt <= '0;
            end else begin
              grav_cnt <= grav_wrap ? '0 : grav_cnt + 1'b1;
              if (grav_wrap) vel <= vel_grav;
            end
          end
          POS: begin
            y0         <= y_new;
            y1         <= y_new + BOX_H_M1;
            on_ground  <= (y_new == GROUND_Y0);
            on_ceiling <= (y_new == '0);
            if (hit) vel <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_player_motion.sv
// Scoreboard bench for player_motion. Each accepted frame tick pushes the
// hand-computed box/flags it should produce; a monitor pops and compares
// three edges after the tick edge.
module tb_player_motion;

  logic       clk = 1'b0;
  logic       reset, frame_tick, thrust, game_over;
  logic [9:0] x0, x1;
  logic [8:0] y0, y1;
  logic       on_ground, on_ceiling, flying;

  typedef struct {
    int y;
    int og;
    int oc;
    int fly;
  } exp_t;

  exp_t exp_q[$];
  logic mark;
  logic [2:0] due;
  int n_checks = 0;
  int n_errors = 0;

  player_motion dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .thrust(thrust),
    .game_over(game_over), .x0(x0), .x1(x1), .y0(y0), .y1(y1),
    .on_ground(on_ground), .on_ceiling(on_ceiling), .flying(flying)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Bench-side pipeline of accepted ticks: bit 2 means the commit is visible.
  always @(posedge clk) due <= {due[1:0], mark & frame_tick};

  // Monitor: pop and compare when a committed update is due.
  always @(negedge clk) begin
    if (due[2]) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL scoreboard: output due but no expectation queued");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("y0", int'(y0), e.y);
        check("y1", int'(y1), e.y + 23);
        check("x0", int'(x0), 100);
        check("x1", int'(x1), 115);
        check("on_ground", int'(on_ground), e.og);
        check("on_ceiling", int'(on_ceiling), e.oc);
        check("flying", int'(flying), e.fly);
      end
    end
  end

  // One accepted frame tick; optionally raise game_over in the VEL cycle.
  task automatic tick(input int y, input int og, input int oc, input int fly,
                      input bit go_vel = 1'b0);
    exp_q.push_back('{y, og, oc, fly});
    @(negedge clk);
    frame_tick = 1'b1;
    mark       = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    mark       = 1'b0;
    if (go_vel) game_over = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; thrust = 1'b0; game_over = 1'b0;
    mark = 1'b0; due = '0;
    repeat (2) @(negedge clk);
    check("rst_y0", int'(y0), 456);
    check("rst_y1", int'(y1), 479);
    check("rst_x0", int'(x0), 100);
    check("rst_x1", int'(x1), 115);
    check("rst_og", int'(on_ground), 1);
    check("rst_oc", int'(on_ceiling), 0);
    check("rst_fly", int'(flying), 0);
    reset = 1'b0;

    // Idle on the ground: no thrust, no motion.
    for (int i = 0; i < 10; i++) tick(456, 1, 0, 0);

    // Take off: vel -2,-4,-6,-6.
    thrust = 1'b1;
    tick(454, 0, 0, 1);
    tick(450, 0, 0, 1);
    tick(444, 0, 0, 1);
    tick(438, 0, 0, 1);

    // Coast: gravity every 2nd tick, velocity saturates at +6, then lands.
    thrust = 1'b0;
    begin
      int ys[27] = '{432, 427, 422, 418, 414, 411, 408, 406, 404, 403, 402,
                     402, 402, 403, 404, 406, 408, 411, 414, 418, 422, 427,
                     432, 438, 444, 450, 456};
      for (int i = 0; i < 27; i++) tick(ys[i], (ys[i] == 456) ? 1 : 0, 0, 1);
    end
    tick(456, 1, 0, 1);   // vel +1 overshoots ground, clamped, vel back to 0
    tick(456, 1, 0, 1);   // no motion without thrust

    // Hold thrust from the ground all the way to the ceiling.
    thrust = 1'b1;
    tick(454, 0, 0, 1);
    tick(450, 0, 0, 1);
    tick(444, 0, 0, 1);
    for (int k = 1; k <= 74; k++) tick(444 - 6 * k, 0, (k == 74) ? 1 : 0, 1);
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 1);

    // Release at the ceiling, drift down, then game over during VEL.
    thrust = 1'b0;
    tick(0, 0, 1, 1);
    tick(1, 0, 0, 1);
    tick(2, 0, 0, 1);
    tick(4, 0, 0, 1);
    tick(4, 0, 0, 0, 1'b1);
    thrust = 1'b1;
    for (int i = 0; i < 20; i++) tick(4, 0, 0, 0);

    // Reset overrides FROZEN.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("frz_rst_y0", int'(y0), 456);
    check("frz_rst_y1", int'(y1), 479);
    check("frz_rst_og", int'(on_ground), 1);
    check("frz_rst_fly", int'(flying), 0);
    reset = 1'b0;
    game_over = 1'b0;

    // Two back-to-back ticks: only the first is taken.
    exp_q.push_back('{454, 0, 0, 1});
    @(negedge clk);
    frame_tick = 1'b1;
    mark = 1'b1;
    @(negedge clk);
    mark = 1'b0;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (4) @(negedge clk);
    tick(450, 0, 0, 1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
